// File: rtl/uvmt_mem_st_mem_arb.sv
// uvmt_mem_st_mem_arb: two-requester round-robin arbiter for one memory port with read-data return routing.
// Optional UVMT_MEM_ST_MEM_ARB_LOCK_EN adds a_lock/b_lock for multi-cycle exclusive ownership.
module uvmt_mem_st_mem_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef UVMT_MEM_ST_MEM_ARB_LOCK_EN
    input  logic                  a_lock,
    input  logic                  b_lock,
`endif
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic {SIDE_A, SIDE_B} side_e;
    side_e prio_ptr, lock_side;
    logic lock_v, a_lk, b_lk, locked, pick_b, win_lock, out_v, out_b;
    logic [RD_LATENCY-1:0] pipe_v, pipe_b;
`ifdef UVMT_MEM_ST_MEM_ARB_LOCK_EN
    assign a_lk = a_lock;
    assign b_lk = b_lock;
`else
    assign a_lk = 1'b0;
    assign b_lk = 1'b0;
`endif
    // A lock only binds while its owner keeps requesting.
    assign locked = lock_v && (lock_side == SIDE_A ? a_req : b_req);
    assign pick_b = locked ? lock_side == SIDE_B : b_req && (!a_req || prio_ptr == SIDE_B);
    assign a_gnt = !reset && a_req && !pick_b;
    assign b_gnt = !reset && b_req && pick_b;
    assign mem_req = a_gnt || b_gnt;
    assign mem_we = a_gnt ? a_we : b_gnt ? b_we : 1'b0;
    assign mem_addr = a_gnt ? a_addr : b_gnt ? b_addr : '0;
    assign mem_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    assign win_lock = a_gnt ? a_lk : b_gnt && b_lk;
    assign out_v = !reset && pipe_v[RD_LATENCY-1];
    assign out_b = pipe_b[RD_LATENCY-1];
    assign a_rvalid = out_v && !out_b;
    assign b_rvalid = out_v && out_b;
    assign a_rdata = a_rvalid ? mem_rdata : '0;
    assign b_rdata = b_rvalid ? mem_rdata : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_ptr <= SIDE_A;
            lock_side <= SIDE_A;
            lock_v <= 1'b0;
            pipe_v <= '0;
            pipe_b <= '0;
        end else begin
            lock_v <= mem_req && win_lock;
            if (mem_req) lock_side <= b_gnt ? SIDE_B : SIDE_A;
            if (a_req && b_req && mem_req && !win_lock) prio_ptr <= b_gnt ? SIDE_A : SIDE_B;
            pipe_v[0] <= mem_req && !mem_we;
            pipe_b[0] <= b_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end
endmodule
